// File: rtl/trace_pkg.sv
// trace_pkg: shared state encoding and entry layout for the trace buffer.
package trace_pkg;
    typedef enum logic [1:0] {IDLE, CAPTURE, POST, READOUT} state_t;
    localparam int TRACE_W   = 129;
    localparam int MSB_LSB   = 0;
    localparam int RT_LSB    = 1;
    localparam int RS_LSB    = 33;
    localparam int INSTR_LSB = 65;
    localparam int PC_LSB    = 97;
endpackage

// File: rtl/trace_ram.sv
// trace_ram: DEPTH x W storage, one synchronous write port, one asynchronous read port.
module trace_ram
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW = $clog2(DEPTH),
    parameter int W = TRACE_W
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/trace_buffer.sv
// trace_buffer: circular capture of core debug outputs, stopping POST_TRIG entries
// after a PC-match trigger, then replaying the window oldest-first over valid/ready.
module trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int POST_TRIG = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arm,
    input  logic        trig_en,
    input  logic [31:0] trig_pc,
    input  logic [31:0] read_addr_pc,
    input  logic [31:0] instruction_out,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        msb,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_pc,
    output logic [31:0] rd_instr,
    output logic [31:0] rd_rs,
    output logic [31:0] rd_rt,
    output logic        rd_msb,
    output logic        triggered,
    output logic        busy,
    output logic [AW:0] count
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] PT   = (AW+1)'(POST_TRIG);

    state_t             r_state;
    logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [AW:0]        r_count, r_post_cnt;
    logic               r_triggered;
    logic               w_we, w_hit, w_to_ro, w_xfer;
    logic [AW-1:0]      w_wr_nxt;
    logic [AW:0]        w_cnt_inc;
    logic [TRACE_W-1:0] w_rdata;

    assign busy      = r_state == CAPTURE || r_state == POST;
    assign triggered = r_triggered;
    assign count     = r_count;
    assign rd_valid  = r_state == READOUT && r_count != '0;
    assign w_we      = busy && !arm;
    assign w_hit     = r_state == CAPTURE && trig_en && read_addr_pc == trig_pc;
    assign w_wr_nxt  = r_wr_ptr + 1'b1;
    assign w_cnt_inc = r_count == FULL ? r_count : r_count + 1'b1;
    assign w_to_ro   = (w_hit && POST_TRIG == 0) || (r_state == POST && r_post_cnt + 1'b1 == PT);
    assign w_xfer    = rd_valid && rd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_post_cnt  <= '0;
            r_triggered <= 1'b0;
        end else if (arm) begin
            r_state     <= CAPTURE;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_post_cnt  <= '0;
            r_triggered <= 1'b0;
        end else begin
            if (w_we) begin
                r_wr_ptr <= w_wr_nxt;
                r_count  <= w_cnt_inc;
            end
            if (w_hit) begin
                r_triggered <= 1'b1;
                r_state     <= POST;
            end
            if (r_state == POST) r_post_cnt <= r_post_cnt + 1'b1;
            // Oldest entry is computed from the pointer and count as they will be after this write.
            if (w_to_ro) begin
                r_state  <= READOUT;
                r_rd_ptr <= w_wr_nxt - w_cnt_inc[AW-1:0];
            end
            if (w_xfer) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count  <= r_count - 1'b1;
                if (r_count == 1) r_state <= IDLE;
            end
        end
    end

    trace_ram #(.DEPTH(DEPTH), .AW(AW), .W(TRACE_W)) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata ({read_addr_pc, instruction_out, rs_val, rt_val, msb}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    // Storage has no reset, so the read fields are forced to zero whenever nothing is presented.
    assign rd_pc    = rd_valid ? w_rdata[PC_LSB +: 32]    : '0;
    assign rd_instr = rd_valid ? w_rdata[INSTR_LSB +: 32] : '0;
    assign rd_rs    = rd_valid ? w_rdata[RS_LSB +: 32]    : '0;
    assign rd_rt    = rd_valid ? w_rdata[RT_LSB +: 32]    : '0;
    assign rd_msb   = rd_valid && w_rdata[MSB_LSB];
endmodule
